serial_add_arbiter: RTL

Bit-serial adder controller that shares a single one-bit full-adder cell, built from two half-adder cells plus an OR, between two requesters. It arbitrates round-robin between the requesters and latches the granted operand pair. It then sequences the pair through the cell LSB-first over WIDTH cycles and returns an N-bit sum with carry-out, tagged with the requester ID. It sits between client logic and the shared adder datapath, trading latency for area.

---
 rtl/serial_add_arbiter_if.sv | 38 +++
 rtl/serial_add_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_arbiter_if
// Purpose  : Request/operand/result bundle between two clients and the
//            shared bit-serial adder arbiter.
// Ports    : req0/a0/b0, req1/a1/b1 -> arbiter   (client side drives)
//            gnt0/gnt1/busy/done/id/sum/carry <- arbiter
//            master modport = client view, slave modport = arbiter view
// Revision : 1.0  initial release
// ============================================================================
interface serial_add_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             id;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, done, id, sum, carry
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, done, id, sum, carry
  );
endinterface
`default_nettype wire

// File: rtl/serial_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_arbiter
// Purpose  : Round-robin arbiter in front of one shared 1-bit full adder
//            (two half adders + OR). The granted operand pair is summed
//            LSB-first over WIDTH cycles; the result is tagged with the ID
//            of the requester it belongs to.
// Ports    : clk_i    rising-edge clock
//            rst_n_i  asynchronous active-low reset
//            bus      serial_add_arbiter_if.slave (requests, operands,
//                     grants, busy, done, id, sum, carry)
// Revision : 1.0  initial release
// ============================================================================
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  wire logic            clk_i,
  input  wire logic            rst_n_i,
  serial_add_arbiter_if.slave  bus
);

  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;   // requester granted most recently
  logic               gid_q, gid_d;     // requester of the operation in flight
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               done_q, done_d;
  logic               id_q, id_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;

  // Shared full-adder cell: two half adders plus an OR for the carry.
  logic w_s1, w_c1, w_sum_bit, w_c2, w_c_next;
  assign w_s1      = a_q[0] ^ b_q[0];
  assign w_c1      = a_q[0] & b_q[0];
  assign w_sum_bit = w_s1 ^ c_q;
  assign w_c2      = w_s1 & c_q;
  assign w_c_next  = w_c1 | w_c2;

  // Result register with the new sum bit shifted in at the MSB. After WIDTH
  // shifts the first (LSB) sum bit has walked down to bit 0.
  logic [WIDTH-1:0] w_res_shift;
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_shift = w_sum_bit;
    end else begin : g_res_wn
      assign w_res_shift = {w_sum_bit, res_q[WIDTH-1:1]};
    end
  endgenerate

  // Requester 1 wins when it asks alone, or when both ask and 0 went last.
  logic w_pick1;
  assign w_pick1 = bus.req1 & (~bus.req0 | ~last_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gid_d   = gid_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done_d  = 1'b0;
    id_d    = id_q;
    sum_d   = sum_q;
    carry_d = carry_q;

    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          a_d     = w_pick1 ? bus.a1 : bus.a0;
          b_d     = w_pick1 ? bus.b1 : bus.b0;
          c_d     = 1'b0;
          cnt_d   = '0;
          gnt0_d  = ~w_pick1;
          gnt1_d  = w_pick1;
          last_d  = w_pick1;
          gid_d   = w_pick1;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = w_res_shift;
        c_d   = w_c_next;
        cnt_d = cnt_q + CNT_W'(1);
        // The last bit lands directly in SUM/CARRY so they are valid for
        // the whole FIN cycle in which DONE is high.
        if (cnt_q == LAST_BIT) begin
          sum_d   = w_res_shift;
          carry_d = w_c_next;
          id_d    = gid_q;
          done_d  = 1'b1;
          state_d = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;   // requester 0 wins the first tie
      gid_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done_q  <= 1'b0;
      id_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done_q  <= done_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.id    = id_q;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;

endmodule
`default_nettype wire
